// File: rtl/pine_bus_pkg.sv
// Shared types and constants for the pine external bus controller.
package pine_bus_pkg;

  localparam int unsigned ADDR_W = 20;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_HOLD = 3'd2,
    ST_DATA = 3'd3,
    ST_TURN = 3'd4
  } state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic ale;
    logic oe_n;
    logic we_n;
    logic pio;
    logic oe_lo;
    logic oe_hi;
  } strb_t;

  // Bus strobes with nothing driven and nothing selected
  localparam strb_t STRB_IDLE = '{ale: 1'b0, oe_n: 1'b1, we_n: 1'b1,
                                  pio: 1'b0, oe_lo: 1'b0, oe_hi: 1'b0};

  function automatic int unsigned cnt_w(input int unsigned a, input int unsigned b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/pine_bus_waitcnt.sv
// Data-phase wait counter: load on entry, saturating decrement, zero flag.
module pine_bus_waitcnt #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero_c
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/pine_bus_ctrl.sv
// Multiplexed 20-bit external bus sequencer: ALE address phase, then a
// wait-stated data phase through the 245 transceivers to the SRAMs.
module pine_bus_ctrl
  import pine_bus_pkg::*;
#(
  parameter int unsigned WAIT_RD = 2,
  parameter int unsigned WAIT_WR = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] bus_ad_o,
  output logic              bus_ad_oe_lo,
  output logic              bus_ad_oe_hi,
  input  logic [DATA_W-1:0] bus_ad_i,
  output logic              ale,
  output logic              oe_n,
  output logic              we_n,
  output logic              pio
);

  localparam int unsigned CNT_W = cnt_w(WAIT_RD, WAIT_WR);

  state_e            r_state, w_state_nx;
  req_t              r_req, w_req;
  strb_t             r_strb, w_strb;
  logic [ADDR_W-1:0] r_ad_o, w_ad_o;
  logic              r_req_ready, r_rsp_valid, w_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              w_acc, w_first, w_rd_cap, w_cnt_zero;

  assign w_acc   = (r_state == ST_IDLE) && req_valid;
  assign w_req   = w_acc ? '{we: req_we, addr: req_addr, wdata: req_wdata} : r_req;
  assign w_first = (r_state == ST_HOLD);

  pine_bus_waitcnt #(.W(CNT_W)) u_waitcnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (r_state == ST_HOLD),
    .i_load_val (r_req.we ? CNT_W'(WAIT_WR) : CNT_W'(WAIT_RD)),
    .i_dec      (r_state == ST_DATA),
    .o_zero_c   (w_cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE: if (req_valid) w_state_nx = ST_ADDR;
      ST_ADDR: w_state_nx = ST_HOLD;
      ST_HOLD: w_state_nx = ST_DATA;
      ST_DATA: if (w_cnt_zero) w_state_nx = ST_TURN;
      ST_TURN: w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // Strobes are derived from the state being entered so they register in step with it
  always_comb begin
    w_strb      = STRB_IDLE;
    w_ad_o      = r_ad_o;
    w_rsp_valid = 1'b0;
    w_rd_cap    = 1'b0;
    case (w_state_nx)
      ST_ADDR: begin
        w_strb.ale   = 1'b1;
        w_strb.oe_lo = 1'b1;
        w_strb.oe_hi = 1'b1;
        w_ad_o       = w_req.addr;
      end
      ST_HOLD: begin
        w_strb.oe_lo = 1'b1;
        w_strb.oe_hi = 1'b1;
      end
      ST_DATA: begin
        w_strb.oe_hi = 1'b1;
        w_strb.pio   = 1'b1;
        w_strb.oe_n  = w_first;
        if (w_req.we) begin
          // First write cycle turns DIR around before the SRAM is selected
          w_strb.oe_lo = 1'b1;
          w_strb.we_n  = 1'b0;
          w_strb.pio   = ~w_first;
          w_ad_o       = {w_req.addr[ADDR_W-1:DATA_W], w_req.wdata};
        end
      end
      ST_TURN: begin
        w_strb.oe_hi = 1'b1;
        if (w_req.we) begin
          w_strb.oe_lo = 1'b1;
          w_strb.we_n  = 1'b0;
          w_strb.oe_n  = 1'b0;
        end else begin
          w_rsp_valid = 1'b1;
          w_rd_cap    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req       <= '0;
      r_strb      <= STRB_IDLE;
      r_ad_o      <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      if (w_acc) r_req <= w_req;
      r_strb      <= w_strb;
      r_ad_o      <= w_ad_o;
      r_req_ready <= (w_state_nx == ST_IDLE);
      r_rsp_valid <= w_rsp_valid;
      if (w_rd_cap) r_rsp_rdata <= bus_ad_i;
    end
  end

  assign req_ready    = r_req_ready;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_rdata    = r_rsp_rdata;
  assign bus_ad_o     = r_ad_o;
  assign bus_ad_oe_lo = r_strb.oe_lo;
  assign bus_ad_oe_hi = r_strb.oe_hi;
  assign ale          = r_strb.ale;
  assign oe_n         = r_strb.oe_n;
  assign we_n         = r_strb.we_n;
  assign pio          = r_strb.pio;

endmodule

// File: tb/tb_pine_bus_ctrl.sv
// Bench for pine_bus_ctrl: board-level 573/138/245/SRAM model plus a
// word-level expected memory, directed and randomized transactions.
module tb_pine_bus_ctrl;

  localparam int unsigned WRD = 2;
  localparam int unsigned WWR = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [19:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic [19:0] bus_ad_o;
  logic        bus_ad_oe_lo, bus_ad_oe_hi;
  logic [15:0] bus_ad_i = 16'h0000;
  logic        ale, oe_n, we_n, pio;

  always #5 clk = ~clk;

  pine_bus_ctrl #(.WAIT_RD(WRD), .WAIT_WR(WWR)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .bus_ad_o     (bus_ad_o),
    .bus_ad_oe_lo (bus_ad_oe_lo),
    .bus_ad_oe_hi (bus_ad_oe_hi),
    .bus_ad_i     (bus_ad_i),
    .ale          (ale),
    .oe_n         (oe_n),
    .we_n         (we_n),
    .pio          (pio)
  );

  int          n_vec = 0;
  int          n_err = 0;
  longint      cyc = 0;
  int          rsp_pulses = 0;
  int          n_reads = 0;
  logic [15:0] sram    [logic [19:0]];
  logic [15:0] ref_mem [logic [19:0]];
  logic [15:0] lat_lo = 16'h0000;
  logic [19:0] wr_addr = 20'h0;
  logic [15:0] wr_data = 16'h0;
  logic        wr_pend = 1'b0;
  logic        prev_we_n = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Board model: 573 latch, live high address into 138, 245 + SRAM, CE#-terminated writes
  always @(negedge clk) begin
    logic [19:0] a;
    if (ale) lat_lo = bus_ad_o[15:0];
    a = {bus_ad_o[19:16], lat_lo};
    check("no_x", 32'($isunknown({ale, oe_n, we_n, pio, bus_ad_oe_lo, bus_ad_oe_hi,
                                  req_ready, rsp_valid, rsp_rdata, bus_ad_o})), 32'd0);
    check("contention", 32'(bus_ad_oe_lo & ~oe_n & we_n), 32'd0);
    check("we_toggle", 32'((we_n != prev_we_n) & ~oe_n), 32'd0);
    prev_we_n = we_n;
    if (rsp_valid) rsp_pulses++;
    if (pio & ~we_n & ~oe_n) begin
      wr_pend = 1'b1;
      wr_addr = a;
      wr_data = bus_ad_oe_lo ? bus_ad_o[15:0] : 16'hDEAD;
    end else if (!pio && wr_pend) begin
      sram[wr_addr] = wr_data;
      wr_pend = 1'b0;
    end
    if (pio & we_n & ~oe_n)  bus_ad_i = sram.exists(a) ? sram[a] : 16'h0000;
    else if (bus_ad_oe_lo)   bus_ad_i = bus_ad_o[15:0];
    else                     bus_ad_i = 16'h0000;
  end

  task automatic issue(input logic we, input logic [19:0] addr, input logic [15:0] data,
                       input bit hold, output longint t_acc);
    int          n;
    int          rsp_k;
    int          pulses;
    int          k;
    logic [15:0] exp;
    n = we ? int'(WWR) : int'(WRD);
    rsp_k = -1;
    pulses = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = data;
    k = 0;
    while (!req_ready && k < 50) begin
      tick();
      k++;
    end
    check("ready_wait", 32'(req_ready), 32'd1);
    tick();
    t_acc = cyc;
    if (!hold) req_valid = 1'b0;
    if (we) ref_mem[addr] = data;
    else    n_reads++;
    exp = ref_mem.exists(addr) ? ref_mem[addr] : 16'h0000;
    for (int i = 1; i <= n + 5; i++) begin
      check("ale_only_addr", 32'(ale), 32'(i == 1));
      if (rsp_valid) begin
        pulses++;
        if (rsp_k < 0) rsp_k = i;
      end
      if (!we && i == n + 4) check("rdata", 32'(rsp_rdata), 32'(exp));
      if (i < n + 5) begin
        check("busy", 32'(req_ready), 32'd0);
        tick();
      end
    end
    check("ready_back", 32'(req_ready), 32'd1);
    check("rsp_lat", 32'(rsp_k), we ? 32'hFFFF_FFFF : 32'(n + 4));
    check("rsp_pulses", 32'(pulses), we ? 32'd0 : 32'd1);
    if (!we) check("rdata_hold", 32'(rsp_rdata), 32'(exp));
  endtask

  function automatic logic [31:0] strobes();
    return 32'({ale, oe_n, we_n, pio, bus_ad_oe_lo, bus_ad_oe_hi, rsp_valid, req_ready});
  endfunction

  localparam logic [31:0] STRB_REST = 32'b0110_0001;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    longint      t1, t2, tdummy;
    logic [19:0] pool [6];
    logic [19:0] ra;
    logic        rwe;
    pool = '{20'h00012, 20'h00001, 20'hE0003, 20'h5AAAA, 20'h1FFFF, 20'hFFFFF};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) tick();
    check("rst_strobes", strobes(), STRB_REST);
    check("rst_rdata", 32'(rsp_rdata), 32'd0);
    rst = 1'b0;
    repeat (3) begin
      tick();
      check("idle_strobes", strobes(), STRB_REST);
    end

    issue(1'b1, 20'h00012, 16'hBEEF, 1'b0, tdummy);
    check("sram_12", 32'(sram.exists(20'h00012) ? sram[20'h00012] : 16'h0), 32'h0000_BEEF);
    issue(1'b0, 20'h00012, 16'h0000, 1'b0, tdummy);

    issue(1'b1, 20'h00001, 16'h1234, 1'b1, t1);
    issue(1'b0, 20'h00001, 16'h0000, 1'b0, t2);
    check("b2b_gap", 32'(t2 - t1), 32'(WWR + 5));

    // Abort a write in DATA c1
    req_valid = 1'b1; req_we = 1'b1; req_addr = 20'h3C0C0; req_wdata = 16'h5555;
    tick();
    req_valid = 1'b0;
    repeat (3) tick();
    check("c1_strobes", 32'({pio, we_n, oe_n}), 32'b100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_strobes", strobes(), STRB_REST);
    tick();
    check("abort_no_rsp", 32'(rsp_valid), 32'd0);
    issue(1'b0, 20'h00012, 16'h0000, 1'b0, tdummy);

    for (int i = 0; i < 24; i++) begin
      ra  = ($urandom_range(0, 3) == 0) ? 20'($urandom) : pool[$urandom_range(0, 5)];
      if (ra[19:8] == 12'h3C0) ra[19] = 1'b0;
      rwe = 1'($urandom_range(0, 1));
      issue(rwe, ra, 16'($urandom), (i != 23) && ($urandom_range(0, 1) == 1), tdummy);
    end
    tick();

    foreach (ref_mem[a]) check("sram_final", 32'(sram.exists(a) ? sram[a] : 16'h0), 32'(ref_mem[a]));
    check("rsp_total", 32'(rsp_pulses), 32'(n_reads));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
